// File: rtl/snn_pkg.sv
// Shared constants for the spiking front end: LFSR polynomial, per-channel
// seed salt, encoder run-controller states and the channel seeding rule.
package snn_pkg;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_SALT = 16'h9E37;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } enc_state_e;

  // Salting decorrelates the channels; an all-zero LFSR would never leave zero.
  function automatic logic [15:0] channel_seed(input logic [15:0] base, input int unsigned ch);
    logic [15:0] salted;
    salted = base ^ 16'(ch * SEED_SALT);
    return (salted == 16'd0) ? 16'd1 : salted;
  endfunction
endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR; load has priority over advance, otherwise it holds.
module lfsr_galois
  import snn_pkg::*;
#(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(LFSR_TAPS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);
  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (advance) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
endmodule

// File: rtl/poisson_spike_encoder.sv
// Poisson rate encoder: per-channel LFSR byte vs. intensity compare, streamed as
// num_steps valid/ready beats under a start/done run controller.
module poisson_spike_encoder
  import snn_pkg::*;
#(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LFSR_W = 16,
  parameter int unsigned STEP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [N_CH*DATA_W-1:0] intensity,
  input  logic [STEP_W-1:0]      num_steps,
  input  logic [LFSR_W-1:0]      seed,
  input  logic                   spike_ready,
  output logic                   spike_valid,
  output logic [N_CH-1:0]        spike_out,
  output logic [STEP_W-1:0]      step_idx,
  output logic                   busy,
  output logic                   done
);
  enc_state_e             state_q, state_d;
  logic [N_CH*DATA_W-1:0] intensity_q, intensity_d;
  logic [STEP_W-1:0]      steps_q, steps_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [LFSR_W-1:0]      seed_q, seed_d;
  logic [N_CH-1:0]        spike_q, spike_d;
  logic [N_CH-1:0]        spike_next;
  logic                   seeding, accept, last_beat;

  assign seeding   = (state_q == ST_SEED);
  assign accept    = (state_q == ST_EMIT) && spike_ready;
  assign last_beat = (step_q == (steps_q - STEP_W'(1)));

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [LFSR_W-1:0] load_val, lfsr_cur, lfsr_adv, lfsr_nxt;

      assign load_val = LFSR_W'(channel_seed(16'(seed_q), gi));
      assign lfsr_adv = (lfsr_cur >> 1) ^ (lfsr_cur[0] ? LFSR_W'(LFSR_TAPS) : '0);
      // Compare against the value the LFSR takes at the coming edge so spike_out is registered.
      assign lfsr_nxt = seeding ? load_val : lfsr_adv;
      assign spike_next[gi] = (lfsr_nxt[DATA_W-1:0] < intensity_q[gi*DATA_W +: DATA_W]);

      lfsr_galois #(
        .LFSR_W (LFSR_W),
        .TAPS   (LFSR_W'(LFSR_TAPS))
      ) u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (seeding),
        .load_val (load_val),
        .advance  (accept),
        .state    (lfsr_cur)
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    intensity_d = intensity_q;
    steps_d     = steps_q;
    seed_d      = seed_q;
    step_d      = step_q;
    spike_d     = spike_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          intensity_d = intensity;
          steps_d     = num_steps;
          seed_d      = seed;
          state_d     = ST_SEED;
        end
      end
      ST_SEED: begin
        step_d = '0;
        if (steps_q == '0) begin
          spike_d = '0;
          state_d = ST_DONE;
        end else begin
          spike_d = spike_next;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (spike_ready) begin
          if (last_beat) begin
            spike_d = '0;
            state_d = ST_DONE;
          end else begin
            step_d  = step_q + STEP_W'(1);
            spike_d = spike_next;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      intensity_q <= '0;
      steps_q     <= '0;
      seed_q      <= '0;
      step_q      <= '0;
      spike_q     <= '0;
    end else begin
      state_q     <= state_d;
      intensity_q <= intensity_d;
      steps_q     <= steps_d;
      seed_q      <= seed_d;
      step_q      <= step_d;
      spike_q     <= spike_d;
    end
  end

  assign spike_valid = (state_q == ST_EMIT);
  assign spike_out   = spike_q;
  assign step_idx    = step_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Bench for poisson_spike_encoder: a beat-queue reference model checked every
// cycle, plus directed runs with hand-computed literal expectations.
module tb_poisson_spike_encoder;
  logic        clk = 1'b0;
  logic        reset_n, start, spike_ready;
  logic [63:0] intensity;
  logic [7:0]  num_steps;
  logic [15:0] seed;
  logic        spike_valid;
  logic [7:0]  spike_out;
  logic [7:0]  step_idx;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // reference model: the run as a queue of expected spike vectors
  bit         m_active = 1'b0, m_done = 1'b0;
  int         m_delay = 0, m_idx = 0, m_ff7 = 0;
  logic [7:0] m_beats[$];

  // observations of accepted beats and done pulses
  int         done_cnt = 0, done_cyc = 0, beat_cnt = 0, ch0_cnt = 0, ch7_cnt = 0;
  logic [7:0] acc_spk[$];
  int         acc_step[$];

  int         t_start, d0, d_before;
  bit         exp_valid;
  logic [7:0] exp_spk;
  logic [2:0] gold [4];

  always #5 clk = ~clk;

  poisson_spike_encoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .intensity   (intensity),
    .num_steps   (num_steps),
    .seed        (seed),
    .spike_ready (spike_ready),
    .spike_valid (spike_valid),
    .spike_out   (spike_out),
    .step_idx    (step_idx),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every beat of a run follows directly from the seeding and stepping rules.
  task automatic model_build(input logic [63:0] inten, input int n, input logic [15:0] sd);
    logic [15:0] l [8];
    logic [7:0]  v, lb, ib;
    m_beats.delete();
    m_ff7 = 0;
    for (int c = 0; c < 8; c++) begin
      l[c] = sd ^ 16'(c * 32'h9E37);
      if (l[c] == 16'h0000) l[c] = 16'h0001;
    end
    for (int k = 0; k < n; k++) begin
      v = 8'h00;
      for (int c = 0; c < 8; c++) begin
        lb = l[c][7:0];
        ib = inten[c*8 +: 8];
        v[c] = (lb < ib);
        if (c == 7 && lb == 8'hFF) m_ff7++;
        l[c] = {1'b0, l[c][15:1]} ^ (l[c][0] ? 16'hB400 : 16'h0000);
      end
      m_beats.push_back(v);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_delay  = 0;
      m_idx    = 0;
      m_beats.delete();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        model_build(intensity, int'(num_steps), seed);
        m_active = 1'b1;
        m_delay  = 1;
        m_idx    = 0;
      end
    end else if (m_delay > 0) begin
      m_delay = 0;
      if (m_beats.size() == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (spike_ready) begin
      void'(m_beats.pop_front());
      m_idx++;
      if (m_beats.size() == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      exp_valid = m_active && (m_delay == 0);
      exp_spk   = exp_valid ? m_beats[0] : 8'h00;
      chk("spike_valid", 32'(spike_valid), 32'(exp_valid));
      chk("spike_out", 32'(spike_out), 32'(exp_spk));
      chk("busy", 32'(busy), 32'(m_active || m_done));
      chk("done", 32'(done), 32'(m_done));
      if (exp_valid) chk("step_idx", 32'(step_idx), 32'(m_idx));
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (spike_valid === 1'b1 && spike_ready === 1'b1) begin
      acc_spk.push_back(spike_out);
      acc_step.push_back(int'(step_idx));
      beat_cnt++;
      if (spike_out[0]) ch0_cnt++;
      if (spike_out[7]) ch7_cnt++;
      $display("beat t=%0d step=%0d spikes=%b", cyc, step_idx, spike_out);
    end
  end

  // mode 1 drives ready 1,0,0 repeating; a start pulse is injected at loop index poke_at.
  task automatic run(input logic [63:0] inten, input int n, input logic [15:0] sd,
                     input int mode, input int poke_at, input int budget);
    acc_spk.delete();
    acc_step.delete();
    beat_cnt = 0;
    ch0_cnt  = 0;
    ch7_cnt  = 0;
    d0 = done_cnt;
    spike_ready = 1'b1;
    intensity = inten;
    num_steps = 8'(n);
    seed = sd;
    start = 1'b1;
    t_start = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      if (mode == 1) spike_ready = ((i % 3) == 0);
      if (i == poke_at) begin
        start = 1'b1;
        intensity = 64'h0;
        seed = 16'hFFFF;
        num_steps = 8'd200;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("run_done_seen", 32'(done_cnt != d0), 32'd1);
    $display("run n=%0d seed=%h beats=%0d done_after=%0d", n, sd, beat_cnt, done_cyc - t_start);
    spike_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    gold = '{3'b111, 3'b111, 3'b101, 3'b001};
    reset_n = 1'b0;
    start = 1'b0;
    spike_ready = 1'b0;
    intensity = '0;
    num_steps = '0;
    seed = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_state", 32'({spike_valid, spike_out, step_idx, busy, done}), 32'h0);
    reset_n = 1'b1;
    tick();

    // golden trace: seed 1, all intensities 0x80
    run({8{8'h80}}, 4, 16'h0001, 0, -1, 20);
    chk("gold_beats", 32'(acc_spk.size()), 32'd4);
    for (int k = 0; k < acc_spk.size() && k < 4; k++) begin
      chk("gold_ch2_0", 32'(acc_spk[k][2:0]), 32'(gold[k]));
      chk("gold_step", 32'(acc_step[k]), 32'(k));
    end
    chk("gold_latency", 32'(done_cyc - t_start), 32'd6);

    // zero / full rate over the longest run
    run({8'hFF, {6{8'h40}}, 8'h00}, 255, 16'hACE1, 0, -1, 300);
    chk("rate_beats", 32'(beat_cnt), 32'd255);
    chk("ch0_never", 32'(ch0_cnt), 32'd0);
    chk("ch7_unless_ff", 32'(ch7_cnt), 32'(255 - m_ff7));
    chk("ch7_rate_high", 32'(ch7_cnt >= 240), 32'd1);
    chk("done_latency_255", 32'(done_cyc - t_start), 32'd257);

    // backpressure
    d_before = done_cnt;
    run({8{8'h5A}}, 8, 16'hBEEF, 1, -1, 60);
    chk("bp_beats", 32'(beat_cnt), 32'd8);
    for (int k = 0; k < acc_step.size(); k++) chk("bp_step_seq", 32'(acc_step[k]), 32'(k));
    chk("bp_done_once", 32'(done_cnt - d_before), 32'd1);

    // zero-length run
    run({8{8'hFF}}, 0, 16'h1111, 0, -1, 10);
    chk("zero_beats", 32'(beat_cnt), 32'd0);
    chk("zero_done_latency", 32'(done_cyc - t_start), 32'd2);

    // start pulsed mid-run is ignored
    d_before = done_cnt;
    run({8{8'hF0}}, 6, 16'h2468, 0, 2, 30);
    chk("poke_beats", 32'(beat_cnt), 32'd6);
    chk("poke_no_restart", 32'(busy), 32'd0);
    chk("poke_done_once", 32'(done_cnt - d_before), 32'd1);

    // seed lock-up on ch1
    run({{6{8'h10}}, 8'd200, 8'h10}, 4, 16'h9E37, 0, -1, 20);
    for (int k = 0; k < acc_spk.size(); k++) chk("lock_ch1_fires", 32'(acc_spk[k][1]), 32'd1);
    chk("lock_ch0_beat0", 32'(acc_spk.size() > 0 ? acc_spk[0][0] : 1'b1), 32'd0);
    run({{6{8'h10}}, 8'd1, 8'h10}, 2, 16'h9E37, 0, -1, 20);
    chk("lock_forced_one_b0", 32'(acc_spk.size() > 0 ? acc_spk[0][1] : 1'b1), 32'd0);
    chk("lock_forced_one_b1", 32'(acc_spk.size() > 1 ? acc_spk[1][1] : 1'b0), 32'd1);

    // reset mid-run at beat 4
    intensity = {8{8'h80}};
    num_steps = 8'd10;
    seed = 16'h1234;
    spike_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 20 && !(spike_valid === 1'b1 && step_idx == 8'd4); i++) tick();
    chk("reach_beat4", 32'(spike_valid === 1'b1 && step_idx == 8'd4), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("midrun_reset", 32'({spike_valid, spike_out, step_idx, busy, done}), 32'h0);
    reset_n = 1'b1;
    repeat (15) tick();
    chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
